datapath_controller: RTL and testbench
======================================

Name: datapath_controller

Overview:
- Multi-cycle control stage that sits directly upstream of the register-file/ALU datapath.
- Accepts 16-bit CR16-style instruction words over a valid/ready handshake and decodes each one.
- Drives the datapath's regEnable, a_select, b_select, use_imm, immediate and opCode inputs, and sequences each instruction through DECODE and EXEC so that exactly one register write occurs per instruction.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  16  instruction word: [15:12] op, [11:8] Rdest, [7:4] ext/immH, [3:0] Rsrc/immL.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  controller can accept an instruction.
- regEnable  output  16  one-hot register write enable to the datapath.
- a_select  output  4  datapath A-operand register select.
- b_select  output  4  datapath B-operand register select.
- use_imm  output  1  selects immediate as the B operand.
- immediate  output  16  extended immediate.
- opCode  output  8  ALU opcode.
- illegal  output  1  one-cycle pulse on a reserved op.
- retired  output  COUNT_WIDTH  count of instructions that issued a register write.

Behaviour:
- Reset: clock and reset are fixed as one clock (clk) with asynchronous, active-high reset (reset); no other polarity or synchronicity is permitted. On reset, all outputs, the IR and retired go to 0 and state goes to IDLE. instr_ready = (state==IDLE) & ~reset.
- States: IDLE, DECODE, EXEC.
  - IDLE: instr_ready=1. When instr_valid & instr_ready, capture instr into IR and go to DECODE. Otherwise stay in IDLE.
  - DECODE: register all decoded outputs from IR; regEnable=0; go to EXEC.
  - EXEC: decoded outputs are held; regEnable=onehot(Rdest) for exactly this cycle, so the datapath writes at the end of the cycle; go to IDLE.
- Latency: 3 cycles per instruction, acceptance edge to acceptance edge.
- Decode, R-form (op==0):
  - a_select=Rdest, b_select=Rsrc, use_imm=0.
  - opCode={4'h0,ext}.
  - immediate=previous value.
- Decode, I-form (op!=0):
  - a_select=Rdest, b_select=Rdest, use_imm=1.
  - opCode={op,4'h0}.
  - imm8=instr[7:0]; immediate=sign-extended imm8.
  - Exception: op==4'hF (LUI) gives immediate={imm8,8'h00}.
- No-write cases: regEnable stays 0 in EXEC for:
  - compare: R-form ext==4'hB, or I-form op==4'hB;
  - NOP: R-form ext==4'h0;
  - reserved op==4'h4.
- Reserved op==4'h4: additionally, illegal=1 during EXEC only.
- Outside EXEC, a_select, b_select, use_imm, immediate and opCode hold their last decoded values. regEnable is 0 in every state except EXEC.
- retired: increments by 1 at the end of each EXEC cycle with a nonzero regEnable. It wraps from all-ones to 0.
- Handshake:
  - instr_valid while not ready is ignored; the controller does not capture instr.
  - The upstream source must hold instr stable until accepted.
  - instr_valid may drop at any time without effect.
- Reset mid-operation: state immediately goes to IDLE and outputs clear. There is no regEnable pulse, and the in-flight instruction is discarded.

Optional Feature:
- DATAPATH_CTRL_BACK_TO_BACK_EN defined:
  - instr_ready is also 1 during EXEC.
  - A handshake in EXEC captures the next instr into IR and goes directly to DECODE.
  - The current write still occurs that cycle.
  - Throughput becomes 2 cycles per instruction.
- Undefined: instr_ready=0 in EXEC, and throughput is 3 cycles.

Test Plan:
- Reset release, then instr=16'h0152 (ADD r1,r2) -> DECODE: a_select=1, b_select=2, use_imm=0, opCode=8'h05, regEnable=0. EXEC: regEnable=16'h0002 for one cycle. retired=1.
- instr=16'h53FF (I-form op 5, r3, imm -1) -> opCode=8'h50, a_select=3, use_imm=1, immediate=16'hFFFF, regEnable=16'h0008 in EXEC.
- instr=16'hF2AB (LUI r2) -> immediate=16'hAB00, regEnable=16'h0004 in EXEC.
- instr=16'h01B2 (CMP), then instr=16'h4100 (reserved) -> regEnable=0 throughout both; illegal=1 only in the second EXEC; retired unchanged.
- Assert reset during DECODE of 16'h0152 -> all outputs immediately 0, no regEnable pulse; after release, instr_ready=1 and retired=0.
- instr_valid held high with 4 queued instructions -> 12 cycles without the macro, 8 cycles with DATAPATH_CTRL_BACK_TO_BACK_EN; retired=4 in both builds.

Source files
------------

// File: rtl/datapath_controller.sv
// Control stage feeding the register-file/ALU datapath: decodes CR16-style words and sequences IDLE -> DECODE -> EXEC.
// Latency: 3 cycles per instruction (2 when DATAPATH_CTRL_BACK_TO_BACK_EN is defined, accepting the next word during EXEC).
// Backpressure: instr_ready is high only in IDLE (also EXEC with DATAPATH_CTRL_BACK_TO_BACK_EN); instr must stay stable until accepted.
module datapath_controller #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [15:0]            regEnable,
  output logic [3:0]             a_select,
  output logic [3:0]             b_select,
  output logic                   use_imm,
  output logic [15:0]            immediate,
  output logic [7:0]             opCode,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [15:0]            ir_q, ir_d;
  logic [15:0]            reg_enable_q, reg_enable_d;
  logic [3:0]             a_select_q, a_select_d;
  logic [3:0]             b_select_q, b_select_d;
  logic                   use_imm_q, use_imm_d;
  logic [15:0]            immediate_q, immediate_d;
  logic [7:0]             op_code_q, op_code_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  // Instruction fields of the captured word
  logic [3:0] ir_op, ir_rdest, ir_ext, ir_rsrc;
  logic [7:0] ir_imm8;
  assign ir_op    = ir_q[15:12];
  assign ir_rdest = ir_q[11:8];
  assign ir_ext   = ir_q[7:4];
  assign ir_rsrc  = ir_q[3:0];
  assign ir_imm8  = ir_q[7:0];

  logic [3:0]  dec_b_select;
  logic        dec_use_imm;
  logic [15:0] dec_immediate;
  logic [7:0]  dec_op_code;
  logic        dec_writes;
  logic        dec_illegal;

  // Decode the IR into datapath controls; R-form keeps the previous immediate
  always_comb begin
    dec_b_select  = ir_rdest;
    dec_use_imm   = 1'b1;
    dec_immediate = {{8{ir_imm8[7]}}, ir_imm8};
    dec_op_code   = {ir_op, 4'h0};
    dec_writes    = 1'b1;
    dec_illegal   = 1'b0;
    if (ir_op == 4'h0) begin
      dec_b_select  = ir_rsrc;
      dec_use_imm   = 1'b0;
      dec_immediate = immediate_q;
      dec_op_code   = {4'h0, ir_ext};
      // NOP and compare produce no register write
      if (ir_ext == 4'h0 || ir_ext == 4'hB) dec_writes = 1'b0;
    end else begin
      if (ir_op == 4'hF) dec_immediate = {ir_imm8, 8'h00};
      if (ir_op == 4'hB) dec_writes = 1'b0;
      if (ir_op == 4'h4) begin
        dec_writes  = 1'b0;
        dec_illegal = 1'b1;
      end
    end
  end

  // Handshake acceptance
  always_comb begin
`ifdef DATAPATH_CTRL_BACK_TO_BACK_EN
    instr_ready = ((state_q == ST_IDLE) || (state_q == ST_EXEC)) && !reset;
`else
    instr_ready = (state_q == ST_IDLE) && !reset;
`endif
  end

  // Next-state and output register computation; write enable and illegal live for one EXEC cycle
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    reg_enable_d = 16'h0000;
    a_select_d   = a_select_q;
    b_select_d   = b_select_q;
    use_imm_d    = use_imm_q;
    immediate_d  = immediate_q;
    op_code_d    = op_code_q;
    illegal_d    = 1'b0;
    retired_d    = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_select_d   = ir_rdest;
        b_select_d   = dec_b_select;
        use_imm_d    = dec_use_imm;
        immediate_d  = dec_immediate;
        op_code_d    = dec_op_code;
        reg_enable_d = dec_writes ? (16'h0001 << ir_rdest) : 16'h0000;
        illegal_d    = dec_illegal;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        if (reg_enable_q != 16'h0000) retired_d = retired_q + COUNT_WIDTH'(1);
        state_d = ST_IDLE;
`ifdef DATAPATH_CTRL_BACK_TO_BACK_EN
        if (instr_valid && instr_ready) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset discards any in-flight write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ir_q         <= 16'h0000;
      reg_enable_q <= 16'h0000;
      a_select_q   <= 4'h0;
      b_select_q   <= 4'h0;
      use_imm_q    <= 1'b0;
      immediate_q  <= 16'h0000;
      op_code_q    <= 8'h00;
      illegal_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      reg_enable_q <= reg_enable_d;
      a_select_q   <= a_select_d;
      b_select_q   <= b_select_d;
      use_imm_q    <= use_imm_d;
      immediate_q  <= immediate_d;
      op_code_q    <= op_code_d;
      illegal_q    <= illegal_d;
      retired_q    <= retired_d;
    end
  end

  assign regEnable = reg_enable_q;
  assign a_select  = a_select_q;
  assign b_select  = b_select_q;
  assign use_imm   = use_imm_q;
  assign immediate = immediate_q;
  assign opCode    = op_code_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: per-instruction phase checks, reset abort, and streaming throughput.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit after the rising edge.
// Expected values are hand-derived constants; the throughput expectation follows DATAPATH_CTRL_BACK_TO_BACK_EN.
module tb_datapath_controller;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] regEnable;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic        use_imm;
  logic [15:0] immediate;
  logic [7:0]  opCode;
  logic        illegal;
  logic [15:0] retired;

  int nvec = 0;
  int nerr = 0;

`ifdef DATAPATH_CTRL_BACK_TO_BACK_EN
  localparam int  EXP_CYCLES    = 8;
  localparam logic EXP_RDY_EXEC = 1'b1;
`else
  localparam int  EXP_CYCLES    = 12;
  localparam logic EXP_RDY_EXEC = 1'b0;
`endif

  datapath_controller #(.COUNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .regEnable   (regEnable),
    .a_select    (a_select),
    .b_select    (b_select),
    .use_imm     (use_imm),
    .immediate   (immediate),
    .opCode      (opCode),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one word from IDLE (called on a falling edge) and check DECODE, EXEC and the following IDLE.
  task automatic run_instr(input string nm, input logic [15:0] w,
                           input logic [3:0] ea, input logic [3:0] eb, input logic eu,
                           input logic [15:0] eimm, input logic [7:0] eop,
                           input logic [15:0] ere, input logic eill, input logic [15:0] eret);
    instr = w;
    instr_valid = 1'b1;
    chk({nm, ".idle_rdy"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({nm, ".dec_re"},  32'(regEnable), 32'h0);
    chk({nm, ".dec_ill"}, 32'(illegal), 32'h0);
    chk({nm, ".dec_rdy"}, 32'(instr_ready), 32'h0);
    @(negedge clk);
    chk({nm, ".a"},       32'(a_select), 32'(ea));
    chk({nm, ".b"},       32'(b_select), 32'(eb));
    chk({nm, ".use_imm"}, 32'(use_imm), 32'(eu));
    chk({nm, ".imm"},     32'(immediate), 32'(eimm));
    chk({nm, ".op"},      32'(opCode), 32'(eop));
    chk({nm, ".exe_re"},  32'(regEnable), 32'(ere));
    chk({nm, ".exe_ill"}, 32'(illegal), 32'(eill));
    chk({nm, ".exe_rdy"}, 32'(instr_ready), 32'(EXP_RDY_EXEC));
    @(negedge clk);
    chk({nm, ".post_re"},  32'(regEnable), 32'h0);
    chk({nm, ".post_ill"}, 32'(illegal), 32'h0);
    chk({nm, ".retired"},  32'(retired), 32'(eret));
  endtask

  logic [15:0] stream [5];

  initial begin
    reset = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    #1;
    chk("rst.re",  32'(regEnable), 32'h0);
    chk("rst.rdy", 32'(instr_ready), 32'h0);
    chk("rst.ret", 32'(retired), 32'h0);
    chk("rst.op",  32'(opCode), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel.rdy", 32'(instr_ready), 32'd1);
    @(negedge clk);

    //        name    word      a     b     use   imm       op     regEn     ill   retired
    run_instr("add",  16'h0152, 4'h1, 4'h2, 1'b0, 16'h0000, 8'h05, 16'h0002, 1'b0, 16'd1);
    run_instr("addi", 16'h53FF, 4'h3, 4'h3, 1'b1, 16'hFFFF, 8'h50, 16'h0008, 1'b0, 16'd2);
    run_instr("lui",  16'hF2AB, 4'h2, 4'h2, 1'b1, 16'hAB00, 8'hF0, 16'h0004, 1'b0, 16'd3);
    run_instr("cmp",  16'h01B2, 4'h1, 4'h2, 1'b0, 16'hAB00, 8'h0B, 16'h0000, 1'b0, 16'd3);
    run_instr("rsv",  16'h4100, 4'h1, 4'h1, 1'b1, 16'h0000, 8'h40, 16'h0000, 1'b1, 16'd3);
    run_instr("posi", 16'h2705, 4'h7, 4'h7, 1'b1, 16'h0005, 8'h20, 16'h0080, 1'b0, 16'd4);
    run_instr("cmpi", 16'hB380, 4'h3, 4'h3, 1'b1, 16'hFF80, 8'hB0, 16'h0000, 1'b0, 16'd4);
    run_instr("r15",  16'h0F3A, 4'hF, 4'hA, 1'b0, 16'hFF80, 8'h03, 16'h8000, 1'b0, 16'd5);
    run_instr("nop",  16'h0000, 4'h0, 4'h0, 1'b0, 16'hFF80, 8'h00, 16'h0000, 1'b0, 16'd5);

    // Reset during DECODE discards the instruction
    instr = 16'h0152;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort.re",  32'(regEnable), 32'h0);
    chk("abort.a",   32'(a_select), 32'h0);
    chk("abort.imm", 32'(immediate), 32'h0);
    chk("abort.ret", 32'(retired), 32'h0);
    chk("abort.rdy", 32'(instr_ready), 32'h0);
    @(negedge clk);
    chk("abort.hold_re", 32'(regEnable), 32'h0);
    reset = 1'b0;
    #1;
    chk("abort.rel_rdy", 32'(instr_ready), 32'd1);
    chk("abort.rel_ret", 32'(retired), 32'h0);
    @(negedge clk);

    // Stream: four writing instructions then a NOP; measure edges from first to fifth acceptance
    stream[0] = 16'h0152;
    stream[1] = 16'h2705;
    stream[2] = 16'h53FF;
    stream[3] = 16'hF2AB;
    stream[4] = 16'h0000;
    begin
      int idx = 0;
      int cyc = 0;
      int t_first = 0;
      int t_last = 0;
      logic acc;
      instr = stream[0];
      instr_valid = 1'b1;
      while (idx < 5 && cyc < 60) begin
        acc = instr_ready && instr_valid;
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin
          if (idx == 0) t_first = cyc;
          if (idx == 4) begin
            t_last = cyc;
            chk("stream.ret4", 32'(retired), 32'd4);
          end
          idx++;
          if (idx < 5) instr = stream[idx];
          else instr_valid = 1'b0;
        end
        @(negedge clk);
      end
      chk("stream.done", 32'(idx), 32'd5);
      chk("stream.cycles", 32'(t_last - t_first), 32'(EXP_CYCLES));
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stream.ret_final", 32'(retired), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
